cc_rd_fill_multi_sm: RTL and testbench
======================================

Name: cc_rd_fill_multi_sm

Overview:
Multi-channel successor to the single-channel CC_RD_FILL executor. It answers one CC_RD_FILL command with the following response packet:
- CSN, then CC (or ~CC on error);
- then, for each enabled channel in ascending order, a channel-ID word followed by that channel's DDR3 fill data.

It sits between the command dispatcher, NUM_CH first-word-fall-through header FIFOs, the DDR3 read controller and the AXIS mux feeding the Aurora TX. Compared with the single-channel block it adds a channel mask, a data-phase stall timeout and an error code.

Parameters:
NUM_CH, 4, number of header FIFO / channel sources (1..16)
CH_W, 2, width of the channel index; must equal clog2(NUM_CH), minimum 1
HDR_W, 152, header FIFO word width
ADDR_W, 23, DDR3 128-bit burst address width
BCNT_W, 24, burst count width; field is hdr[HDR_W-1 -: BCNT_W]
TIMEOUT_W, 20, stall timeout counter width; timeout fires after 2^TIMEOUT_W-1 idle cycles

Ports:
clk  in  1  local clock
reset  in  1  synchronous, active-high
run_sm  in  1  dispatcher enable; low forces IDLE
ch_mask  in  NUM_CH  enabled channels, sampled in IDLE
sm_running  out  1  high in every state except IDLE
sm_done  out  1  one-cycle pulse in DONE
err_code  out  2  0 = ok, 1 = empty FIFO or zero mask, 2 = data timeout; held until next command
tx_tvalid  out  1  CSN / CC / channel-ID word valid
tx_tlast  out  1  final word of an error packet
tx_tready  in  1  TX FIFO ready
send_csn  out  1  mux select: CSN
send_cmd  out  1  mux select: CC
send_inv_cmd  out  1  mux select: ~CC
send_ch_id  out  1  mux select: channel-ID word
ch_sel  out  CH_W  current channel index
hdr_fifo_empty  in  NUM_CH  per-channel FIFO empty
hdr_fifo_rd_en  out  NUM_CH  one-hot pop pulse
hdr_fifo_out  in  NUM_CH*HDR_W  channel c occupies [c*HDR_W +: HDR_W]
fixed_addr  in  ADDR_W  override start address
en_fixed_addr  in  1  use fixed_addr
acq_done_latch  in  1  acquisition safely finished
ddr3_rd_start_addr  out  ADDR_W  first burst address
ddr3_rd_burst_cnt  out  BCNT_W  bursts to read
enable_reading  out  1  high while the DDR3 read is requested
reading_done  in  1  asynchronous; two-flop synchronised internally
use_ddr3_data  out  1  AXIS mux selects DDR3 data
aurora_ddr3_accept  in  1  one 32-bit DDR3 word accepted
initial_fill_num_wr  in  1  clear the per-channel fill counters
seq_mismatch  out  1  one-cycle pulse: header fill number ≠ expected

Behaviour:
- Reset, or run_sm low: state goes to IDLE and every output is 0. Fill counters clear only on reset or initial_fill_num_wr.
- States and transitions:
  - IDLE→WAIT_ACQ, latching ch_mask.
  - WAIT_ACQ holds until acq_done_latch=1, then goes to CHK.
  - CHK→ERROR if the mask is 0 or any enabled channel's FIFO is empty (err_code=1, nothing popped: all-or-nothing). Otherwise CHK→ECHO_CSN.
  - ERROR→ECHO_CSN.
- ECHO_CSN waits for tx_tready. Once seen, it drives a one-cycle tx_tvalid with send_csn. ECHO_CC does the same with send_cmd, or send_inv_cmd plus tx_tlast when err_code≠0. After an error it goes to DONE.
- SEL_CH sets ch_sel to the lowest enabled channel not yet served.
- LOAD_HDR, one cycle:
  - Pulse hdr_fifo_rd_en[ch_sel].
  - Load start address: fixed_addr if en_fixed_addr, otherwise hdr[53 +: ADDR_W].
  - Load burst count.
  - Load word counter = {bcnt, 2'b00}, width BCNT_W+2.
  - Compare hdr[11:0] with that channel's 12-bit fill counter. On mismatch, pulse seq_mismatch (informational, no abort). Increment the counter with 12-bit wrap.
- SEND_CH_ID: wait for tx_tready, then a one-cycle tx_tvalid with send_ch_id.
- GET_DATA: enable_reading=1 and use_ddr3_data=1.
  - Each aurora_ddr3_accept decrements the word counter; it saturates at 0.
  - Exit when the synchronised reading_done=1 and the word counter is 0 (registered compare, one-cycle lag allowed). Zero-burst headers exit as soon as reading_done is seen.
  - The timeout counter clears on every accept and on entry. When it reaches all-ones: err_code=2, go to DONE.
- NEXT_CH: go to SEL_CH if enabled channels remain, else DONE. enable_reading must drop for at least one cycle between channels.
- DONE: pulse sm_done; use_ddr3_data stays 1 only if err_code=0; go to IDLE.
- run_sm dropping mid-packet aborts immediately; no FIFO pop occurs after the abort.

Test Plan:
- mask=4'b0101, headers on channels 0 and 2 with bcnt=3, tready=1 → CSN, CC, ID0, 12 accepts, ID2, 12 accepts; hdr_fifo_rd_en pulses 0001 then 0100; sm_done once; err_code=0.
- mask=4'b0011 with channel 1 empty → CSN, ~CC with tx_tlast; no rd_en pulse; err_code=1; sm_done.
- acq_done_latch=0 for 50 cycles → remains in WAIT_ACQ with sm_running=1 and no tvalid; proceeds after it rises.
- TIMEOUT_W=4, stop accepts mid-fill → after 15 idle cycles err_code=2, sm_done, use_ddr3_data=0 in DONE.
- Header fill numbers 0, 1, 3 on one channel after initial_fill_num_wr → seq_mismatch pulses only on the third.
- tready held low 10 cycles in ECHO_CSN, then run_sm dropped → IDLE, all outputs 0, FIFO not popped.

Source files
------------

// File: rtl/cc_rd_fill_multi_sm.sv
// rtl/cc_rd_fill_multi_sm.sv - multi-channel CC_RD_FILL executor
// Answers one command with CSN, CC/~CC, then per enabled channel an ID word plus DDR3 fill data.
module cc_rd_fill_multi_sm #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int HDR_W     = 152,
  parameter int ADDR_W    = 23,
  parameter int BCNT_W    = 24,
  parameter int TIMEOUT_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run_sm,
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic                    sm_running,
  output logic                    sm_done,
  output logic [1:0]              err_code,
  output logic                    tx_tvalid,
  output logic                    tx_tlast,
  input  logic                    tx_tready,
  output logic                    send_csn,
  output logic                    send_cmd,
  output logic                    send_inv_cmd,
  output logic                    send_ch_id,
  output logic [CH_W-1:0]         ch_sel,
  input  logic [NUM_CH-1:0]       hdr_fifo_empty,
  output logic [NUM_CH-1:0]       hdr_fifo_rd_en,
  input  logic [NUM_CH*HDR_W-1:0] hdr_fifo_out,
  input  logic [ADDR_W-1:0]       fixed_addr,
  input  logic                    en_fixed_addr,
  input  logic                    acq_done_latch,
  output logic [ADDR_W-1:0]       ddr3_rd_start_addr,
  output logic [BCNT_W-1:0]       ddr3_rd_burst_cnt,
  output logic                    enable_reading,
  input  logic                    reading_done,
  output logic                    use_ddr3_data,
  input  logic                    aurora_ddr3_accept,
  input  logic                    initial_fill_num_wr,
  output logic                    seq_mismatch
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_ACQ, S_CHK, S_ERROR, S_ECHO_CSN, S_ECHO_CC,
    S_SEL_CH, S_LOAD_HDR, S_SEND_CH_ID, S_GET_DATA, S_NEXT_CH, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CH-1:0]    mask_q, mask_d, rem_q, rem_d;
  logic [CH_W-1:0]      ch_sel_q, ch_sel_d, first_ch;
  logic [1:0]           err_q, err_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [BCNT_W+1:0]    wcnt_q, wcnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [11:0]          fill_q [NUM_CH];
  logic                 rd_done_meta_q, rd_done_q;
  logic                 fill_bump;
  logic [HDR_W-1:0]     hdr;

  assign hdr = hdr_fifo_out[int'(ch_sel_q)*HDR_W +: HDR_W];

  assign ch_sel             = run_sm ? ch_sel_q : '0;
  assign err_code           = run_sm ? err_q : 2'd0;
  assign ddr3_rd_start_addr = run_sm ? addr_q : '0;
  assign ddr3_rd_burst_cnt  = run_sm ? bcnt_q : '0;

  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (rem_q[i]) first_ch = CH_W'(i);
  end

  always_comb begin
    state_d = state_q; mask_d = mask_q; rem_d = rem_q; ch_sel_d = ch_sel_q;
    err_d = err_q; addr_d = addr_q; bcnt_d = bcnt_q; wcnt_d = wcnt_q; tmo_d = tmo_q;
    sm_running = 1'b0; sm_done = 1'b0; tx_tvalid = 1'b0; tx_tlast = 1'b0;
    send_csn = 1'b0; send_cmd = 1'b0; send_inv_cmd = 1'b0; send_ch_id = 1'b0;
    hdr_fifo_rd_en = '0; enable_reading = 1'b0; use_ddr3_data = 1'b0;
    seq_mismatch = 1'b0; fill_bump = 1'b0;
    if (!run_sm) begin
      // Abort: everything returns to a clean idle, fill counters excepted.
      state_d = S_IDLE; err_d = '0; ch_sel_d = '0; addr_d = '0; bcnt_d = '0;
      rem_d = '0; mask_d = '0;
    end else begin
      sm_running = (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_ACQ;
          mask_d  = ch_mask;
          err_d   = '0;
        end
        S_WAIT_ACQ: if (acq_done_latch) state_d = S_CHK;
        S_CHK: begin
          if (mask_q == '0 || |(mask_q & hdr_fifo_empty)) begin
            err_d   = 2'd1;
            state_d = S_ERROR;
          end else begin
            rem_d   = mask_q;
            state_d = S_ECHO_CSN;
          end
        end
        S_ERROR: state_d = S_ECHO_CSN;
        S_ECHO_CSN: begin
          send_csn = 1'b1;
          if (tx_tready) begin
            tx_tvalid = 1'b1;
            state_d   = S_ECHO_CC;
          end
        end
        S_ECHO_CC: begin
          send_cmd     = (err_q == 2'd0);
          send_inv_cmd = (err_q != 2'd0);
          if (tx_tready) begin
            tx_tvalid = 1'b1;
            tx_tlast  = (err_q != 2'd0);
            state_d   = (err_q != 2'd0) ? S_DONE : S_SEL_CH;
          end
        end
        S_SEL_CH: begin
          ch_sel_d = first_ch;
          state_d  = S_LOAD_HDR;
        end
        S_LOAD_HDR: begin
          hdr_fifo_rd_en[ch_sel_q] = 1'b1;
          addr_d       = en_fixed_addr ? fixed_addr : hdr[53 +: ADDR_W];
          bcnt_d       = hdr[HDR_W-1 -: BCNT_W];
          wcnt_d       = {hdr[HDR_W-1 -: BCNT_W], 2'b00};
          seq_mismatch = (hdr[11:0] != fill_q[ch_sel_q]);
          fill_bump    = 1'b1;
          rem_d[ch_sel_q] = 1'b0;
          tmo_d        = '0;
          state_d      = S_SEND_CH_ID;
        end
        S_SEND_CH_ID: begin
          send_ch_id = 1'b1;
          if (tx_tready) begin
            tx_tvalid = 1'b1;
            state_d   = S_GET_DATA;
          end
        end
        S_GET_DATA: begin
          enable_reading = 1'b1;
          use_ddr3_data  = 1'b1;
          if (aurora_ddr3_accept) begin
            tmo_d = '0;
            if (wcnt_q != '0) wcnt_d = wcnt_q - 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
          if (rd_done_q && wcnt_q == '0) begin
            state_d = S_NEXT_CH;
          end else if (tmo_q == '1) begin
            err_d   = 2'd2;
            state_d = S_DONE;
          end
        end
        S_NEXT_CH: state_d = (rem_q != '0) ? S_SEL_CH : S_DONE;
        S_DONE: begin
          sm_done       = 1'b1;
          use_ddr3_data = (err_q == 2'd0);
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE; mask_q <= '0; rem_q <= '0; ch_sel_q <= '0; err_q <= '0;
      addr_q <= '0; bcnt_q <= '0; wcnt_q <= '0; tmo_q <= '0;
      rd_done_meta_q <= 1'b0; rd_done_q <= 1'b0;
    end else begin
      state_q <= state_d; mask_q <= mask_d; rem_q <= rem_d; ch_sel_q <= ch_sel_d;
      err_q <= err_d; addr_q <= addr_d; bcnt_q <= bcnt_d; wcnt_q <= wcnt_d; tmo_q <= tmo_d;
      rd_done_meta_q <= reading_done;
      rd_done_q      <= rd_done_meta_q;
    end
  end

  // Expected fill numbers survive aborts; only reset or an explicit write clears them.
  always_ff @(posedge clk) begin
    if (reset || initial_fill_num_wr) begin
      for (int i = 0; i < NUM_CH; i++) fill_q[i] <= '0;
    end else if (fill_bump) begin
      fill_q[ch_sel_q] <= fill_q[ch_sel_q] + 12'd1;
    end
  end

endmodule

// File: tb/tb_cc_rd_fill_multi_sm.sv
// tb/tb_cc_rd_fill_multi_sm.sv - randomized bench for cc_rd_fill_multi_sm against a packet-level model
module tb_cc_rd_fill_multi_sm;
  localparam int NUM_CH = 4, CH_W = 2, HDR_W = 152, ADDR_W = 23, BCNT_W = 24, TIMEOUT_W = 4;
  typedef logic [HDR_W-1:0] hdr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset, run_sm, sm_running, sm_done, tx_tvalid, tx_tlast, tx_tready;
  logic                    send_csn, send_cmd, send_inv_cmd, send_ch_id, en_fixed_addr, acq_done_latch;
  logic                    enable_reading, reading_done, use_ddr3_data, aurora_ddr3_accept;
  logic                    initial_fill_num_wr, seq_mismatch;
  logic [NUM_CH-1:0]       ch_mask, hdr_fifo_empty, hdr_fifo_rd_en;
  logic [1:0]              err_code;
  logic [CH_W-1:0]         ch_sel;
  logic [NUM_CH*HDR_W-1:0] hdr_fifo_out;
  logic [ADDR_W-1:0]       fixed_addr, ddr3_rd_start_addr;
  logic [BCNT_W-1:0]       ddr3_rd_burst_cnt;
  logic                    any_out;

  cc_rd_fill_multi_sm #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .HDR_W(HDR_W), .ADDR_W(ADDR_W), .BCNT_W(BCNT_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .reset(reset), .run_sm(run_sm), .ch_mask(ch_mask), .sm_running(sm_running),
    .sm_done(sm_done), .err_code(err_code), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_tready(tx_tready), .send_csn(send_csn), .send_cmd(send_cmd), .send_inv_cmd(send_inv_cmd),
    .send_ch_id(send_ch_id), .ch_sel(ch_sel), .hdr_fifo_empty(hdr_fifo_empty),
    .hdr_fifo_rd_en(hdr_fifo_rd_en), .hdr_fifo_out(hdr_fifo_out), .fixed_addr(fixed_addr),
    .en_fixed_addr(en_fixed_addr), .acq_done_latch(acq_done_latch),
    .ddr3_rd_start_addr(ddr3_rd_start_addr), .ddr3_rd_burst_cnt(ddr3_rd_burst_cnt),
    .enable_reading(enable_reading), .reading_done(reading_done), .use_ddr3_data(use_ddr3_data),
    .aurora_ddr3_accept(aurora_ddr3_accept), .initial_fill_num_wr(initial_fill_num_wr),
    .seq_mismatch(seq_mismatch)
  );

  assign any_out = |{sm_running, sm_done, err_code, tx_tvalid, tx_tlast, send_csn, send_cmd,
                     send_inv_cmd, send_ch_id, ch_sel, hdr_fifo_rd_en, ddr3_rd_start_addr,
                     ddr3_rd_burst_cnt, enable_reading, use_ddr3_data, seq_mismatch};

  int   errors = 0, checks = 0;
  hdr_t fifo_q [NUM_CH][$];
  int   fill_model [NUM_CH];
  logic [NUM_CH-1:0] pop_pend;
  int   ddr_active, ddr_left, stall_after, cyc, last_acc_cyc, done_cyc;
  bit   tready_force, tready_low, saw_tvalid;
  int   obs_tx[$], obs_pop[$], exp_rd_addr[$], exp_rd_bcnt[$];
  int   obs_acc, obs_mis, obs_done, obs_err, obs_use, total_mis;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic hdr_t mk_hdr(input int bcnt, input int addr, input int fill);
    hdr_t h = '0;
    h[HDR_W-1 -: BCNT_W] = BCNT_W'(bcnt);
    h[53 +: ADDR_W]      = ADDR_W'(addr);
    h[52:12]             = 41'({$urandom(), $urandom()});
    h[11:0]              = 12'(fill);
    return h;
  endfunction

  // One clock: update the FIFO/DDR3/TX environment, then observe what the DUT does this cycle.
  task automatic step();
    int code;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < NUM_CH; c++)
      if (pop_pend[c] && fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
    pop_pend = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hdr_fifo_empty[c] = (fifo_q[c].size() == 0);
      hdr_fifo_out[c*HDR_W +: HDR_W] = (fifo_q[c].size() > 0) ? fifo_q[c][0] : '0;
    end
    aurora_ddr3_accept = 1'b0;
    reading_done = 1'b0;
    if (!enable_reading) begin
      ddr_active = 0;
    end else begin
      if (ddr_active == 0) begin
        ddr_active = 1;
        ddr_left = int'(ddr3_rd_burst_cnt) * 4;
        if (exp_rd_addr.size() > 0) begin
          check_eq("rd_start_addr", ddr3_rd_start_addr, exp_rd_addr.pop_front());
          check_eq("rd_burst_cnt", ddr3_rd_burst_cnt, exp_rd_bcnt.pop_front());
        end else begin
          check_eq("unexpected_read", 1, 0);
        end
      end
      if (ddr_left > 0 && stall_after != 0 && $urandom_range(3) != 0) begin
        aurora_ddr3_accept = 1'b1;
        ddr_left--;
        if (stall_after > 0) stall_after--;
      end
      reading_done = (ddr_left == 0) && !aurora_ddr3_accept;
    end
    tx_tready = tready_low ? 1'b0 : (tready_force ? 1'b1 : ($urandom_range(2) != 0));
    #1;
    if (tx_tvalid) saw_tvalid = 1'b1;
    if (tx_tvalid && tx_tready) begin
      code = send_csn ? 100 : send_cmd ? 200 : send_inv_cmd ? 300 : send_ch_id ? 400 + int'(ch_sel) : 999;
      if (tx_tlast) code += 1000;
      obs_tx.push_back(code);
    end
    if (hdr_fifo_rd_en != '0) begin
      obs_pop.push_back(int'(hdr_fifo_rd_en));
      pop_pend = hdr_fifo_rd_en;
    end
    if (aurora_ddr3_accept) begin obs_acc++; last_acc_cyc = cyc; end
    if (seq_mismatch) obs_mis++;
    if (sm_done) begin obs_done++; obs_err = int'(err_code); obs_use = int'(use_ddr3_data); done_cyc = cyc; end
  endtask

  // Plans the whole response packet from the FIFO contents, runs the command, compares.
  task automatic run_cmd(input logic [NUM_CH-1:0] mask, input bit fixed, input int acq_delay, input int stall);
    int exp_tx[$], exp_pop[$];
    int exp_err, exp_acc, exp_mis, not_run, budget;
    bit bad;
    hdr_t h;
    exp_acc = 0; exp_mis = 0;
    fixed_addr = ADDR_W'($urandom());
    en_fixed_addr = fixed;
    bad = (mask == '0);
    for (int c = 0; c < NUM_CH; c++) if (mask[c] && fifo_q[c].size() == 0) bad = 1'b1;
    exp_tx.push_back(100);
    if (bad) begin
      exp_err = 1;
      exp_tx.push_back(1300);
    end else begin
      exp_err = 0;
      exp_tx.push_back(200);
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          h = fifo_q[c][0];
          exp_tx.push_back(400 + c);
          exp_pop.push_back(1 << c);
          exp_rd_addr.push_back(fixed ? int'(fixed_addr) : int'(h[53 +: ADDR_W]));
          exp_rd_bcnt.push_back(int'(h[HDR_W-1 -: BCNT_W]));
          if (int'(h[11:0]) != fill_model[c]) exp_mis++;
          fill_model[c] = (fill_model[c] + 1) % 4096;
          exp_acc += 4 * int'(h[HDR_W-1 -: BCNT_W]);
          if (stall >= 0) begin
            exp_err = 2;
            exp_acc = stall;
            break;
          end
        end
      end
    end
    obs_tx.delete(); obs_pop.delete();
    obs_acc = 0; obs_mis = 0; obs_done = 0; obs_err = -1; obs_use = -1; saw_tvalid = 1'b0;
    stall_after = stall;
    ch_mask = mask; run_sm = 1'b1; acq_done_latch = 1'b0; not_run = 0;
    for (int i = 0; i < acq_delay; i++) begin
      step();
      if (!sm_running) not_run++;
    end
    if (acq_delay >= 10) begin
      check_eq("wait_acq_running", not_run, 0);
      check_eq("wait_acq_no_tvalid", saw_tvalid, 0);
    end
    acq_done_latch = 1'b1;
    budget = 0;
    while (obs_done == 0 && budget < 3000) begin step(); budget++; end
    if (obs_done == 0) check_eq("done_within_budget", 0, 1);
    run_sm = 1'b0; acq_done_latch = 1'b0;
    step(); step();
    check_eq("done_pulses", obs_done, 1);
    check_eq("err_code", obs_err, exp_err);
    check_eq("use_ddr3_in_done", obs_use, (exp_err == 0) ? 1 : 0);
    check_eq("tx_words", obs_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++) check_eq("tx_word", obs_tx[i], exp_tx[i]);
    check_eq("pops", obs_pop.size(), exp_pop.size());
    for (int i = 0; i < exp_pop.size() && i < obs_pop.size(); i++) check_eq("pop_onehot", obs_pop[i], exp_pop[i]);
    check_eq("accepts", obs_acc, exp_acc);
    check_eq("seq_mismatch", obs_mis, exp_mis);
    check_eq("reads_left", exp_rd_addr.size(), 0);
    if (stall >= 0) check_eq("timeout_latency_ok", (done_cyc - last_acc_cyc >= 16 && done_cyc - last_acc_cyc <= 18) ? 1 : 0, 1);
    total_mis += obs_mis;
    exp_rd_addr.delete(); exp_rd_bcnt.delete();
  endtask

  task automatic flush();
    for (int c = 0; c < NUM_CH; c++) fifo_q[c].delete();
  endtask

  initial begin
    logic [NUM_CH-1:0] m;
    int fl;
    reset = 1'b1; run_sm = 1'b1; ch_mask = '1; tx_tready = 1'b0; hdr_fifo_empty = '1;
    hdr_fifo_out = '0; fixed_addr = '0; en_fixed_addr = 1'b0; acq_done_latch = 1'b1;
    reading_done = 1'b0; aurora_ddr3_accept = 1'b0; initial_fill_num_wr = 1'b0;
    pop_pend = '0; ddr_active = 0; ddr_left = 0; stall_after = -1; cyc = 0; total_mis = 0;
    tready_force = 1'b0; tready_low = 1'b0;
    for (int c = 0; c < NUM_CH; c++) fill_model[c] = 0;
    step(); step(); step();
    check_eq("reset_outputs_zero", any_out, 0);
    run_sm = 1'b0; acq_done_latch = 1'b0;
    step();
    reset = 1'b0;
    step();
    check_eq("idle_outputs_zero", any_out, 0);

    // Two channels, full handshake, bcnt=3 each.
    flush(); tready_force = 1'b1;
    fifo_q[0].push_back(mk_hdr(3, 23'h12345, fill_model[0]));
    fifo_q[2].push_back(mk_hdr(3, 23'h7abcd, fill_model[2]));
    run_cmd(4'b0101, 1'b0, 0, -1);
    tready_force = 1'b0;

    // Enabled channel 1 empty: error packet, nothing popped.
    flush();
    fifo_q[0].push_back(mk_hdr(2, 23'h00100, fill_model[0]));
    run_cmd(4'b0011, 1'b0, 0, -1);
    check_eq("err_no_pop_ch0", fifo_q[0].size(), 1);

    // Acquisition not done for 50 cycles.
    flush();
    fifo_q[3].push_back(mk_hdr(1, 23'h00200, fill_model[3]));
    run_cmd(4'b1000, 1'b1, 50, -1);

    // Fill sequence 0, 1, 3 after clearing the counters.
    flush();
    initial_fill_num_wr = 1'b1; step(); initial_fill_num_wr = 1'b0;
    for (int c = 0; c < NUM_CH; c++) fill_model[c] = 0;
    total_mis = 0;
    fifo_q[1].push_back(mk_hdr(1, 23'h1, 0));
    fifo_q[1].push_back(mk_hdr(0, 23'h2, 1));
    fifo_q[1].push_back(mk_hdr(1, 23'h3, 3));
    for (int i = 0; i < 3; i++) run_cmd(4'b0010, 1'b0, 0, -1);
    check_eq("fill_seq_total_mismatch", total_mis, 1);

    // Data stall mid-fill: timeout.
    flush();
    fifo_q[1].push_back(mk_hdr(3, 23'h04444, fill_model[1]));
    fifo_q[2].push_back(mk_hdr(1, 23'h05555, fill_model[2]));
    run_cmd(4'b0110, 1'b0, 0, 5);
    stall_after = -1;

    // Abort while waiting for tready in ECHO_CSN.
    flush();
    fifo_q[0].push_back(mk_hdr(1, 23'h6, fill_model[0]));
    obs_tx.delete(); obs_pop.delete();
    tready_low = 1'b1; ch_mask = 4'b0001; run_sm = 1'b1; acq_done_latch = 1'b1;
    for (int i = 0; i < 13; i++) step();
    check_eq("abort_running_before", sm_running, 1);
    run_sm = 1'b0; acq_done_latch = 1'b0;
    step();
    check_eq("abort_outputs_zero", any_out, 0);
    step(); step();
    check_eq("abort_no_tx", obs_tx.size(), 0);
    check_eq("abort_no_pop", obs_pop.size(), 0);
    check_eq("abort_fifo_kept", fifo_q[0].size(), 1);
    tready_low = 1'b0;

    // Randomized commands.
    for (int it = 0; it < 25; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(1) == 0 && fifo_q[c].size() < 3) begin
          fl = (fill_model[c] + fifo_q[c].size() + (($urandom_range(4) == 0) ? 1 : 0)) % 4096;
          fifo_q[c].push_back(mk_hdr($urandom_range(3), int'($urandom()), fl));
        end
      end
      m = NUM_CH'($urandom_range(15));
      run_cmd(m, 1'($urandom_range(1)), $urandom_range(2), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
